fetch_sequencer: RTL and testbench

- Execution-side counterpart of the instruction decoder: consumes its cycle-control, program-counter and address-bus control lines.
- Produces the `cycle` count and `IR` opcode that the decoder reads.
- Owns the 16-bit program counter and the registered address bus (ABH:ABL).
- Runs the power-up reset-vector fetch before handing control to the decoder.

---
 rtl/cpu6502_pkg.sv | 34 +++
 rtl/fetch_sequencer_pc_unit.sv | 59 +++++
 rtl/fetch_sequencer.sv | 167 ++++++++++++++++
 tb/tb_fetch_sequencer.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu6502_pkg.sv
// Shared definitions for the 6502-style core: sequencer states, vector
// addresses and opcode constants used by both the decoder and the sequencer.
package cpu6502_pkg;

    // Power-up sequencing: fetch the reset vector low byte, then the high byte, then run.
    typedef enum logic [1:0] {
        VEC_LO = 2'd0,
        VEC_HI = 2'd1,
        RUN    = 2'd2
    } seq_state_e;

    // Vector table (low byte addresses; high byte lives at the next address).
    localparam logic [15:0] NMI_VECTOR   = 16'hFFFA;
    localparam logic [15:0] RESET_VECTOR = 16'hFFFC;
    localparam logic [15:0] IRQ_VECTOR   = 16'hFFFE;

    // Opcodes shared with the instruction decoder.
    localparam logic [7:0] OP_BRK     = 8'h00;
    localparam logic [7:0] OP_JSR     = 8'h20;
    localparam logic [7:0] OP_RTI     = 8'h40;
    localparam logic [7:0] OP_JMP_ABS = 8'h4C;
    localparam logic [7:0] OP_RTS     = 8'h60;
    localparam logic [7:0] OP_JMP_IND = 8'h6C;
    localparam logic [7:0] OP_LDA_IMM = 8'hA9;
    localparam logic [7:0] OP_LDA_ABS = 8'hAD;
    localparam logic [7:0] OP_STA_ABS = 8'h8D;
    localparam logic [7:0] OP_NOP     = 8'hEA;

    // Address of the high byte of a vector whose low byte sits at vec.
    function automatic logic [15:0] vec_hi_addr(input logic [15:0] vec);
        return vec + 16'd1;
    endfunction

endpackage

// File: rtl/fetch_sequencer_pc_unit.sv
// Program counter register with its increment logic and the PC-to-address-bus
// muxes (PCL onto ADL, PCH onto ADH). The vector bytes are loaded here during
// the power-up fetch; decoder-driven updates apply only once running.
module fetch_sequencer_pc_unit (
    input  logic        clk_ph2,
    input  logic        rst,
    input  logic        run_en_i,
    input  logic        vec_lo_ld_i,
    input  logic        vec_hi_ld_i,
    input  logic [7:0]  data_i,
    input  logic        inc_i,
    input  logic        pcl_en_i,
    input  logic        pch_en_i,
    input  logic        pcl_adl_i,
    input  logic        pch_adh_i,
    input  logic [7:0]  ext_adl_i,
    input  logic [7:0]  ext_adh_i,
    output logic [15:0] pc_o,
    output logic [7:0]  adl_o,
    output logic [7:0]  adh_o
);

    logic [15:0] pc_q;
    logic [15:0] pc_d;

    // Next PC: vector byte loads, full 16-bit increment, or low-byte-only increment.
    always_comb begin
        pc_d = pc_q;
        if (vec_lo_ld_i) begin
            pc_d[7:0] = data_i;
        end else if (vec_hi_ld_i) begin
            pc_d[15:8] = data_i;
        end else if (run_en_i && inc_i && pcl_en_i && pch_en_i) begin
            pc_d = pc_q + 16'd1;
        end else if (run_en_i && inc_i && pcl_en_i) begin
            pc_d[7:0] = pc_q[7:0] + 8'd1;
        end else begin
            pc_d = pc_q;
        end
    end

    // PC register with synchronous active-low reset.
    always_ff @(posedge clk_ph2) begin
        if (!rst) begin
            pc_q <= 16'h0000;
        end else begin
            pc_q <= pc_d;
        end
    end

    // Internal address buses: the PC source always uses the pre-increment value.
    always_comb begin
        adl_o = pcl_adl_i ? pc_q[7:0]  : ext_adl_i;
        adh_o = pch_adh_i ? pc_q[15:8] : ext_adh_i;
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Execution-side sequencer for the instruction decoder: runs the reset-vector
// fetch, then owns the cycle counter, instruction register, program counter
// and the registered address bus {ABH,ABL}.
module fetch_sequencer #(
    parameter logic [15:0] RESET_VECTOR = cpu6502_pkg::RESET_VECTOR,
    parameter int          CYCLE_W      = 3
) (
    input  logic               clk_ph2,
    input  logic               rst,
    input  logic               I_cycle,
    input  logic               R_cycle,
    input  logic               I_PC,
    input  logic               PCL_PCL,
    input  logic               PCH_PCH,
    input  logic               PCL_ADL,
    input  logic               PCH_ADH,
    input  logic               ADL_ABL,
    input  logic               ADH_ABH,
    input  logic [7:0]         ext_adl,
    input  logic [7:0]         ext_adh,
    input  logic [7:0]         data_in,
    output logic [CYCLE_W-1:0] cycle,
    output logic [7:0]         IR,
    output logic [15:0]        addr,
    output logic [15:0]        pc,
    output logic               run,
    output logic               seq_err
);

    import cpu6502_pkg::*;

    localparam logic [CYCLE_W-1:0] CYCLE_ZERO  = {CYCLE_W{1'b0}};
    localparam logic [CYCLE_W-1:0] CYCLE_ONE   = {{(CYCLE_W-1){1'b0}}, 1'b1};
    localparam logic [CYCLE_W-1:0] CYCLE_MAX   = {CYCLE_W{1'b1}};
    localparam logic [15:0]        VEC_HI_ADDR = vec_hi_addr(RESET_VECTOR);

    seq_state_e         state_q, state_d;
    logic [CYCLE_W-1:0] cycle_q, cycle_d;
    logic [7:0]         ir_q, ir_d;
    logic [15:0]        addr_q, addr_d;
    logic               run_q, run_d;
    logic               seq_err_q, seq_err_d;
    logic               first_q, first_d;   // high for the first RUN cycle only
    logic               vec_lo_ld_s;
    logic               vec_hi_ld_s;
    logic               run_en_s;
    logic [7:0]         adl_s;
    logic [7:0]         adh_s;

    assign run_en_s = (state_q == RUN);

    fetch_sequencer_pc_unit u_pc_unit (
        .clk_ph2     (clk_ph2),
        .rst         (rst),
        .run_en_i    (run_en_s),
        .vec_lo_ld_i (vec_lo_ld_s),
        .vec_hi_ld_i (vec_hi_ld_s),
        .data_i      (data_in),
        .inc_i       (I_PC),
        .pcl_en_i    (PCL_PCL),
        .pch_en_i    (PCH_PCH),
        .pcl_adl_i   (PCL_ADL),
        .pch_adh_i   (PCH_ADH),
        .ext_adl_i   (ext_adl),
        .ext_adh_i   (ext_adh),
        .pc_o        (pc),
        .adl_o       (adl_s),
        .adh_o       (adh_s)
    );

    // Next-state logic: vector fetch sequencing, then decoder-driven updates in RUN.
    always_comb begin
        state_d     = state_q;
        cycle_d     = cycle_q;
        ir_d        = ir_q;
        addr_d      = addr_q;
        run_d       = run_q;
        seq_err_d   = seq_err_q;
        first_d     = 1'b0;
        vec_lo_ld_s = 1'b0;
        vec_hi_ld_s = 1'b0;
        case (state_q)
            VEC_LO: begin
                // data_in carries the byte at RESET_VECTOR presented this cycle.
                vec_lo_ld_s = 1'b1;
                addr_d      = VEC_HI_ADDR;
                state_d     = VEC_HI;
            end
            VEC_HI: begin
                // Cycle 7 makes the decoder's default branch fetch the first opcode.
                vec_hi_ld_s = 1'b1;
                addr_d      = VEC_HI_ADDR;
                state_d     = RUN;
                run_d       = 1'b1;
                cycle_d     = CYCLE_MAX;
                first_d     = 1'b1;
            end
            RUN: begin
                if (R_cycle) begin
                    cycle_d = CYCLE_ZERO;
                end else if (I_cycle) begin
                    cycle_d = cycle_q + CYCLE_ONE;
                    // The entry value of all-ones is not an overflow on the first edge.
                    if ((cycle_q == CYCLE_MAX) && !first_q) begin
                        seq_err_d = 1'b1;
                    end else begin
                        seq_err_d = seq_err_q;
                    end
                end else begin
                    cycle_d = cycle_q;
                end

                if (cycle_q == CYCLE_ZERO) begin
                    ir_d = data_in;
                end else begin
                    ir_d = ir_q;
                end

                if (ADL_ABL) begin
                    addr_d[7:0] = adl_s;
                end else begin
                    addr_d[7:0] = addr_q[7:0];
                end

                if (ADH_ABH) begin
                    addr_d[15:8] = adh_s;
                end else begin
                    addr_d[15:8] = addr_q[15:8];
                end
            end
            default: begin
                state_d = VEC_LO;
                run_d   = 1'b0;
                addr_d  = RESET_VECTOR;
                cycle_d = CYCLE_ZERO;
            end
        endcase
    end

    // Sequencer state registers with synchronous active-low reset.
    always_ff @(posedge clk_ph2) begin
        if (!rst) begin
            state_q   <= VEC_LO;
            cycle_q   <= CYCLE_ZERO;
            ir_q      <= 8'h00;
            addr_q    <= RESET_VECTOR;
            run_q     <= 1'b0;
            seq_err_q <= 1'b0;
            first_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cycle_q   <= cycle_d;
            ir_q      <= ir_d;
            addr_q    <= addr_d;
            run_q     <= run_d;
            seq_err_q <= seq_err_d;
            first_q   <= first_d;
        end
    end

    assign cycle   = cycle_q;
    assign IR      = ir_q;
    assign addr    = addr_q;
    assign run     = run_q;
    assign seq_err = seq_err_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer.
module tb_fetch_sequencer;

    logic        clk_ph2;
    logic        rst;
    logic        I_cycle, R_cycle, I_PC, PCL_PCL, PCH_PCH;
    logic        PCL_ADL, PCH_ADH, ADL_ABL, ADH_ABH;
    logic [7:0]  ext_adl, ext_adh, data_in;
    logic [2:0]  cycle;
    logic [7:0]  IR;
    logic [15:0] addr;
    logic [15:0] pc;
    logic        run;
    logic        seq_err;

    int checks = 0;
    int errors = 0;

    fetch_sequencer #(.RESET_VECTOR(16'hFFFC), .CYCLE_W(3)) dut (
        .clk_ph2 (clk_ph2),
        .rst     (rst),
        .I_cycle (I_cycle),
        .R_cycle (R_cycle),
        .I_PC    (I_PC),
        .PCL_PCL (PCL_PCL),
        .PCH_PCH (PCH_PCH),
        .PCL_ADL (PCL_ADL),
        .PCH_ADH (PCH_ADH),
        .ADL_ABL (ADL_ABL),
        .ADH_ABH (ADH_ABH),
        .ext_adl (ext_adl),
        .ext_adh (ext_adh),
        .data_in (data_in),
        .cycle   (cycle),
        .IR      (IR),
        .addr    (addr),
        .pc      (pc),
        .run     (run),
        .seq_err (seq_err)
    );

    initial clk_ph2 = 1'b0;
    always #5 clk_ph2 = ~clk_ph2;

    // One rising edge; returns on the following falling edge for drive/sample.
    task automatic step();
        @(posedge clk_ph2);
        @(negedge clk_ph2);
    endtask

    task automatic clear_ctrl();
        I_cycle = 1'b0; R_cycle = 1'b0; I_PC = 1'b0; PCL_PCL = 1'b0; PCH_PCH = 1'b0;
        PCL_ADL = 1'b0; PCH_ADH = 1'b0; ADL_ABL = 1'b0; ADH_ABH = 1'b0;
        ext_adl = 8'h00; ext_adh = 8'h00; data_in = 8'h00;
    endtask

    // Reset, then feed the two vector bytes so the sequencer enters RUN.
    task automatic do_vector(input logic [7:0] lo, input logic [7:0] hi);
        clear_ctrl();
        rst = 1'b0;
        step();
        rst = 1'b1;
        data_in = lo;
        step();
        data_in = hi;
        step();
        data_in = 8'h00;
    endtask

    task automatic test_reset();
        clear_ctrl();
        rst = 1'b0;
        I_cycle = 1'b1; I_PC = 1'b1; PCL_PCL = 1'b1; PCH_PCH = 1'b1;
        ADL_ABL = 1'b1; ADH_ABH = 1'b1; ext_adl = 8'h55; ext_adh = 8'h66; data_in = 8'h77;
        step();
        step();
        checks++; if (addr !== 16'hFFFC) begin errors++; $display("FAIL reset_addr: got %h expected fffc", addr); end
        checks++; if (cycle !== 3'd0) begin errors++; $display("FAIL reset_cycle: got %0d expected 0", cycle); end
        checks++; if (IR !== 8'h00) begin errors++; $display("FAIL reset_ir: got %h expected 00", IR); end
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL reset_pc: got %h expected 0000", pc); end
        checks++; if (run !== 1'b0 || seq_err !== 1'b0) begin errors++; $display("FAIL reset_flags: got run=%b err=%b expected 0 0", run, seq_err); end
    endtask

    task automatic test_reset_vector();
        clear_ctrl();
        rst = 1'b1;
        data_in = 8'h34;
        step();
        checks++; if (addr !== 16'hFFFD || run !== 1'b0) begin errors++; $display("FAIL vec_lo: got addr=%h run=%b expected fffd 0", addr, run); end
        data_in = 8'h12;
        step();
        checks++; if (addr !== 16'hFFFD) begin errors++; $display("FAIL vec_hi_addr: got %h expected fffd", addr); end
        checks++; if (pc !== 16'h1234) begin errors++; $display("FAIL vec_pc: got %h expected 1234", pc); end
        checks++; if (run !== 1'b1 || cycle !== 3'd7) begin errors++; $display("FAIL vec_run: got run=%b cycle=%0d expected 1 7", run, cycle); end
        clear_ctrl();
        R_cycle = 1'b1; I_PC = 1'b1; PCL_PCL = 1'b1; PCH_PCH = 1'b1;
        PCL_ADL = 1'b1; PCH_ADH = 1'b1; ADL_ABL = 1'b1; ADH_ABH = 1'b1;
        step();
        checks++; if (addr !== 16'h1234) begin errors++; $display("FAIL first_fetch_addr: got %h expected 1234", addr); end
        checks++; if (pc !== 16'h1235) begin errors++; $display("FAIL first_fetch_pc: got %h expected 1235", pc); end
        checks++; if (cycle !== 3'd0 || seq_err !== 1'b0) begin errors++; $display("FAIL first_fetch_cycle: got cycle=%0d err=%b expected 0 0", cycle, seq_err); end
    endtask

    task automatic test_opcode_fetch();
        clear_ctrl();
        data_in = 8'h69; I_cycle = 1'b1;
        step();
        checks++; if (IR !== 8'h69 || cycle !== 3'd1) begin errors++; $display("FAIL opcode_load: got IR=%h cycle=%0d expected 69 1", IR, cycle); end
        clear_ctrl();
        data_in = 8'hAA;
        step();
        checks++; if (IR !== 8'h69 || cycle !== 3'd1) begin errors++; $display("FAIL opcode_hold: got IR=%h cycle=%0d expected 69 1", IR, cycle); end
    endtask

    task automatic test_pc_wrap();
        do_vector(8'hFF, 8'hFF);
        checks++; if (pc !== 16'hFFFF) begin errors++; $display("FAIL pc_ffff_load: got %h expected ffff", pc); end
        I_PC = 1'b1; PCL_PCL = 1'b1; PCH_PCH = 1'b1;
        step();
        checks++; if (pc !== 16'h0000) begin errors++; $display("FAIL pc_wrap16: got %h expected 0000", pc); end
        do_vector(8'hFF, 8'h12);
        I_PC = 1'b1; PCL_PCL = 1'b1; PCH_PCH = 1'b0;
        step();
        checks++; if (pc !== 16'h1200) begin errors++; $display("FAIL pc_no_carry: got %h expected 1200", pc); end
        I_PC = 1'b1; PCL_PCL = 1'b0; PCH_PCH = 1'b1;
        step();
        checks++; if (pc !== 16'h1200) begin errors++; $display("FAIL pc_hold: got %h expected 1200", pc); end
    endtask

    task automatic test_mixed_addr();
        clear_ctrl();
        ext_adl = 8'h42; ext_adh = 8'h00; ADL_ABL = 1'b1; ADH_ABH = 1'b1;
        step();
        checks++; if (addr !== 16'h0042 || pc !== 16'h1200) begin errors++; $display("FAIL mixed_ext: got addr=%h pc=%h expected 0042 1200", addr, pc); end
        clear_ctrl();
        ext_adl = 8'h99; PCH_ADH = 1'b1; ADH_ABH = 1'b1;
        step();
        checks++; if (addr !== 16'h1242) begin errors++; $display("FAIL mixed_pch: got %h expected 1242", addr); end
    endtask

    task automatic test_counter();
        clear_ctrl();
        R_cycle = 1'b1;
        step();
        clear_ctrl();
        I_cycle = 1'b1;
        for (int i = 0; i < 3; i++) step();
        checks++; if (cycle !== 3'd3) begin errors++; $display("FAIL count_to_3: got %0d expected 3", cycle); end
        R_cycle = 1'b1;
        step();
        checks++; if (cycle !== 3'd0) begin errors++; $display("FAIL r_priority: got %0d expected 0", cycle); end
        R_cycle = 1'b0;
        for (int i = 0; i < 7; i++) step();
        checks++; if (cycle !== 3'd7 || seq_err !== 1'b0) begin errors++; $display("FAIL count_to_7: got cycle=%0d err=%b expected 7 0", cycle, seq_err); end
        step();
        checks++; if (cycle !== 3'd0 || seq_err !== 1'b1) begin errors++; $display("FAIL overflow: got cycle=%0d err=%b expected 0 1", cycle, seq_err); end
        clear_ctrl();
        R_cycle = 1'b1;
        step();
        checks++; if (seq_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", seq_err); end
    endtask

    task automatic test_midop_reset();
        clear_ctrl();
        I_cycle = 1'b1; data_in = 8'h5A;
        step();
        data_in = 8'h00;
        step();
        checks++; if (cycle !== 3'd2 || IR !== 8'h5A) begin errors++; $display("FAIL midop_setup: got cycle=%0d IR=%h expected 2 5a", cycle, IR); end
        I_cycle = 1'b1; I_PC = 1'b1; PCL_PCL = 1'b1; PCH_PCH = 1'b1; ADL_ABL = 1'b1;
        rst = 1'b0;
        step();
        checks++; if (run !== 1'b0 || cycle !== 3'd0 || IR !== 8'h00) begin errors++; $display("FAIL midop_state: got run=%b cycle=%0d IR=%h expected 0 0 00", run, cycle, IR); end
        checks++; if (addr !== 16'hFFFC || pc !== 16'h0000 || seq_err !== 1'b0) begin errors++; $display("FAIL midop_addr: got addr=%h pc=%h err=%b expected fffc 0000 0", addr, pc, seq_err); end
        clear_ctrl();
        rst = 1'b1;
        data_in = 8'h78;
        step();
        checks++; if (addr !== 16'hFFFD || run !== 1'b0) begin errors++; $display("FAIL refetch_lo: got addr=%h run=%b expected fffd 0", addr, run); end
        data_in = 8'h56;
        step();
        checks++; if (pc !== 16'h5678 || run !== 1'b1 || cycle !== 3'd7) begin errors++; $display("FAIL refetch_hi: got pc=%h run=%b cycle=%0d expected 5678 1 7", pc, run, cycle); end
        clear_ctrl();
        I_cycle = 1'b1;
        step();
        checks++; if (cycle !== 3'd0 || seq_err !== 1'b0) begin errors++; $display("FAIL entry_wrap: got cycle=%0d err=%b expected 0 0", cycle, seq_err); end
    endtask

    initial begin
        rst = 1'b0;
        clear_ctrl();
        @(negedge clk_ph2);
        test_reset();
        test_reset_vector();
        test_opcode_fetch();
        test_pc_wrap();
        test_mixed_addr();
        test_counter();
        test_midop_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
